// File: rtl/numbers_flat_pkg.sv
// numbers_flat_pkg: shared types and helpers for the numbers_flat_streamer
// family (FSM state encoding, frame counter width, beat-count helper).
package numbers_flat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } flat_state_e;

    localparam int FRAME_CNT_W = 8;

    // Number of beats needed to carry a_w bits in b_w-bit beats.
    function automatic int ceil_div(input int a_w, input int b_w);
        return (a_w + b_w - 1) / b_w;
    endfunction

endpackage

// File: rtl/numbers_flat_beat_sel.sv
// numbers_flat_beat_sel: combinational beat selector. Picks beat beat_idx_i
// of the snapshot, MSB-first; the final partial beat is left-aligned and
// zero-padded in its low bits.
module numbers_flat_beat_sel
    import numbers_flat_pkg::*;
#(
    parameter int OUT_W  = 80,
    parameter int BEAT_W = 32,
    localparam int NBEATS = ceil_div(OUT_W, BEAT_W),
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic [OUT_W-1:0]  snap_i,
    input  logic [IDX_W-1:0]  beat_idx_i,
    output logic [BEAT_W-1:0] beat_o
);

    // Padded width is a whole number of beats; the pad lives at the LSB end.
    localparam int PAD_W = NBEATS * BEAT_W;

    logic [PAD_W-1:0] padded_s;
    logic [PAD_W-1:0] shifted_s;

    // Left-align the snapshot, shift the wanted beat to the top, take it.
    always_comb begin
        padded_s  = PAD_W'(snap_i) << (PAD_W - OUT_W);
        shifted_s = padded_s << (32'(beat_idx_i) * BEAT_W);
        beat_o    = shifted_s[PAD_W-1 -: BEAT_W];
    end

endmodule

// File: rtl/numbers_flat_streamer.sv
// numbers_flat_streamer: snapshots a flattened number vector on start_i and
// streams it MSB-first as BEAT_W-bit beats over valid/ready.
// Optional feature macro: NUMBERS_FLAT_PARITY_EN adds m_parity_o, the
// XOR-reduction of m_data_o, registered alongside the data.
module numbers_flat_streamer
    import numbers_flat_pkg::*;
#(
    parameter int OUT_W  = 80,
    parameter int BEAT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [OUT_W-1:0]       flat_i,
    output logic                   busy_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [BEAT_W-1:0]      m_data_o,
    output logic                   m_last_o,
    output logic                   done_o,
`ifdef NUMBERS_FLAT_PARITY_EN
    output logic                   m_parity_o,
`endif
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int NBEATS = ceil_div(OUT_W, BEAT_W);
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    flat_state_e             state_q, state_d;
    logic [OUT_W-1:0]        snap_q, snap_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRAME_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [BEAT_W-1:0]       data_q, data_d;
    logic [BEAT_W-1:0]       sel_data_s;
    logic                    send_d_s;

`ifdef NUMBERS_FLAT_PARITY_EN
    logic                    parity_q, parity_d;

    function automatic logic beat_parity(input logic [BEAT_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Outputs are registered, so the selector looks at the next-cycle
    // snapshot and beat index.
    numbers_flat_beat_sel #(
        .OUT_W  (OUT_W),
        .BEAT_W (BEAT_W)
    ) u_beat_sel (
        .snap_i     (snap_d),
        .beat_idx_i (idx_d),
        .beat_o     (sel_data_s)
    );

    // Next-state logic: capture, beat advance on handshake, frame count.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SEND;
                    snap_d  = flat_i;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (valid_q && m_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + FRAME_CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        send_d_s = (state_d == SEND);
        valid_d  = send_d_s;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        last_d   = send_d_s && (idx_d == LAST_IDX);
        if (send_d_s) begin
            data_d = sel_data_s;
        end else begin
            data_d = '0;
        end
`ifdef NUMBERS_FLAT_PARITY_EN
        parity_d = beat_parity(data_d);
`endif
    end

    // State, snapshot, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
`ifdef NUMBERS_FLAT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
`ifdef NUMBERS_FLAT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign m_valid_o   = valid_q;
    assign m_data_o    = data_q;
    assign m_last_o    = last_q;
    assign done_o      = done_q;
    assign frame_cnt_o = cnt_q;
`ifdef NUMBERS_FLAT_PARITY_EN
    assign m_parity_o  = parity_q;
`endif

endmodule

// File: tb/tb_numbers_flat_streamer.sv
// Directed self-checking bench for numbers_flat_streamer (default 80/32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_numbers_flat_streamer;

    localparam logic [79:0] F0 = 80'h0123_4567_89AB_CDEF_F00D;
    localparam logic [31:0] B0 = 32'h01234567;
    localparam logic [31:0] B1 = 32'h89ABCDEF;
    localparam logic [31:0] B2 = 32'hF00D0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [79:0] flat_i;
    logic        busy_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;
    logic        m_last_o;
    logic        done_o;
    logic [7:0]  frame_cnt_o;
`ifdef NUMBERS_FLAT_PARITY_EN
    logic        m_parity_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    numbers_flat_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .flat_i      (flat_i),
        .busy_o      (busy_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .done_o      (done_o),
`ifdef NUMBERS_FLAT_PARITY_EN
        .m_parity_o  (m_parity_o),
`endif
        .frame_cnt_o (frame_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
        check({tag, "_valid"}, 32'(m_valid_o), 32'd1);
        check({tag, "_busy"},  32'(busy_o),    32'd1);
        check({tag, "_data"},  m_data_o,       exp_data);
        check({tag, "_last"},  32'(m_last_o),  32'(exp_last));
`ifdef NUMBERS_FLAT_PARITY_EN
        check({tag, "_par"},   32'(m_parity_o), 32'(^exp_data));
`endif
    endtask

    // Full frame with a zero-wait sink; cnt_before is the count entering it.
    task automatic run_frame(input string tag, input logic [7:0] cnt_before);
        logic [7:0] cnt_after;
        cnt_after = cnt_before + 8'd1;
        @(negedge clk); flat_i = F0; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check_beat({tag, "_b0"}, B0, 1'b0);
        @(negedge clk);
        check_beat({tag, "_b1"}, B1, 1'b0);
        @(negedge clk);
        check_beat({tag, "_b2"}, B2, 1'b1);
        @(negedge clk);
        check({tag, "_done"},      32'(done_o),    32'd1);
        check({tag, "_done_busy"}, 32'(busy_o),    32'd1);
        check({tag, "_done_vld"},  32'(m_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done_o),      32'd0);
        check({tag, "_idle_busy"}, 32'(busy_o),      32'd0);
        check({tag, "_cnt"},       32'(frame_cnt_o), 32'(cnt_after));
    endtask

    // Unchecked frame used to advance the counter; bounded wait on done_o.
    task automatic quick_frame();
        int w;
        @(negedge clk); start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        w = 0;
        while (!done_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("qf_done", 32'(done_o), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; flat_i = '0; m_ready_i = 1'b0;

        // Reset state
        #23;
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_valid", 32'(m_valid_o),   32'd0);
        check("rst_last",  32'(m_last_o),    32'd0);
        check("rst_data",  m_data_o,         32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_cnt",   32'(frame_cnt_o), 32'd0);
`ifdef NUMBERS_FLAT_PARITY_EN
        check("rst_par",   32'(m_parity_o),  32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy",  32'(busy_o),    32'd0);
        check("idle_valid", 32'(m_valid_o), 32'd0);

        // Basic frame
        run_frame("basic", 8'd0);

        // Backpressure on beat 1
        @(negedge clk); flat_i = F0; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check_beat("bp_b0", B0, 1'b0);
        @(negedge clk);
        check_beat("bp_b1", B1, 1'b0);
        m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_beat("bp_hold", B1, 1'b0);
        end
        m_ready_i = 1'b1;
        @(negedge clk);
        check_beat("bp_b2", B2, 1'b1);
        @(negedge clk);
        check("bp_done", 32'(done_o), 32'd1);
        @(negedge clk);
        check("bp_cnt",  32'(frame_cnt_o), 32'd2);
        check("bp_idle", 32'(busy_o),      32'd0);

        // Snapshot frozen, start ignored during SEND
        @(negedge clk); flat_i = F0; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0; flat_i = {80{1'b1}};
        check_beat("snap_b0", B0, 1'b0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check_beat("snap_b1", B1, 1'b0);
        @(negedge clk);
        check_beat("snap_b2", B2, 1'b1);
        @(negedge clk);
        check("snap_done", 32'(done_o), 32'd1);
        @(negedge clk);
        check("snap_nodone", 32'(done_o),    32'd0);
        check("snap_idle",   32'(m_valid_o), 32'd0);
        check("snap_cnt",    32'(frame_cnt_o), 32'd3);
        @(negedge clk);
        check("snap_noqueue", 32'(busy_o), 32'd0);

        // Mid-frame asynchronous reset
        @(negedge clk); flat_i = F0; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check_beat("mr_b0", B0, 1'b0);
        @(negedge clk);
        check_beat("mr_b1", B1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(m_valid_o),   32'd0);
        check("mr_busy",  32'(busy_o),      32'd0);
        check("mr_data",  m_data_o,         32'd0);
        check("mr_cnt",   32'(frame_cnt_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_rst", 8'd0);

        // Counter wrap: 1 -> 255 -> 0
        for (int i = 0; i < 254; i++) begin
            quick_frame();
        end
        check("pre_wrap_cnt", 32'(frame_cnt_o), 32'd255);
        run_frame("wrap", 8'd255);

`ifdef NUMBERS_FLAT_PARITY_EN
        // Hand-computed parity of the three reference beats
        @(negedge clk); flat_i = F0; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check("par_b0", 32'(m_parity_o), 32'd0);
        @(negedge clk);
        check("par_b1", 32'(m_parity_o), 32'd0);
        @(negedge clk);
        check("par_b2", 32'(m_parity_o), 32'd1);
        repeat (2) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/numbers_flat_streamer.md
# numbers_flat_streamer

Controller that sequences readout of a flattened number-constant output vector, the `out_flat` bus of the numbers wrapper family. On a start request it snapshots the whole vector and streams it MSB-first as fixed-width beats over a valid/ready interface. It sits between a wrapped numbers module and the coverage/fuzz harness's capture sink.

## Interface
- `OUT_W`, default 80: width of the flattened vector being streamed.
- `BEAT_W`, default 32: width of each output beat.
- `NBEATS`, derived: ceil(`OUT_W`/`BEAT_W`). This is a localparam, not overridable.
- `clk` input 1: single clock. Everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: capture-and-stream request, sampled each cycle.
- `flat_i` input `OUT_W`: flattened vector from the wrapper's `out_flat`.
- `busy_o` output 1: a frame is in progress.
- `m_valid_o` output 1: beat valid.
- `m_ready_i` input 1: sink ready.
- `m_data_o` output `BEAT_W`: current beat.
- `m_last_o` output 1: current beat is the final beat of the frame.
- `done_o` output 1: one-cycle pulse after the final beat is accepted.
- `frame_cnt_o` output 8: completed-frame counter.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - If `start_i`=1, latch `flat_i` into the snapshot register, clear `beat_idx`, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `m_valid_o`=1.
  - `m_data_o` = snapshot bits [`OUT_W`-1-`beat_idx`*`BEAT_W` -: `BEAT_W`].
  - The final partial beat is left-aligned and zero-padded in its low bits.
  - `m_last_o` = (`beat_idx`==`NBEATS`-1).
  - On handshake (`m_valid_o`&&`m_ready_i`): if not last, increment `beat_idx`; if last, go to DONE.
- DONE:
  - `done_o`=1 for exactly this one cycle.
  - `frame_cnt_o` increments, wrapping 255→0.
  - Unconditional return to IDLE.
- `start_i` is ignored in SEND and DONE. It is not queued.
- The snapshot is frozen for the whole frame. Changes on `flat_i` after capture do not affect the beats.
- `busy_o`=1 in SEND and DONE.
- Reset values: state IDLE, `busy_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `done_o`=0, `frame_cnt_o`=0, snapshot=0, `beat_idx`=0.
- If `OUT_W` is a multiple of `BEAT_W`, no padding is applied.

## Timing
- `start_i` high at edge N: `m_valid_o` and `busy_o` are high from cycle N+1.
- Zero-wait-state sink: one beat per cycle. A frame takes `NBEATS`+2 cycles from start to IDLE.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_last_o` hold stable. `m_valid_o` never drops before the handshake.
- Last beat accepted at edge M:
  - `done_o`=1 and `busy_o`=1 during cycle M+1.
  - IDLE from M+2, so the earliest next capture is at edge M+2.
- `m_ready_i` high while `m_valid_o`=0 has no effect.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous). The frame is abandoned and `frame_cnt_o` is not incremented.
- Reset deassertion is synchronized externally. The block acts on the first edge after release.

## Configuration
- Macro: `NUMBERS_FLAT_PARITY_EN`.
- Defined:
  - Extra output `m_parity_o` (1 bit) = XOR-reduction of `m_data_o`.
  - Valid with the same timing as `m_data_o`. Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `numbers_flat_pkg` holds:
  - FSM state enum (IDLE/SEND/DONE).
  - `FRAME_CNT_W`=8.
  - A function computing ceil-divide for `NBEATS`.
- One sub-module, `numbers_flat_beat_sel`: a purely combinational slice/pad selector.
  - Inputs: snapshot, `beat_idx`.
  - Output: `BEAT_W` data.
  - Parameterized by `OUT_W` and `BEAT_W`.
- FSM, counters and registers live in the top module.

## Test plan
- Reset state: hold `rst_n`=0 → all outputs 0; release, idle 5 cycles → `busy_o`=0, `m_valid_o`=0.
- Basic frame (defaults, `m_ready_i`=1):
  - Stimulus: `flat_i`=80'h0123_4567_89AB_CDEF_F00D, pulse `start_i`.
  - Beats: 32'h01234567, 32'h89ABCDEF, 32'hF00D0000 on consecutive cycles; `m_last_o` on the third only.
  - Then `done_o` pulses once and `frame_cnt_o`=1.
- Backpressure: same frame with `m_ready_i` low for 3 cycles on beat 1 → beat 1 holds 32'h89ABCDEF with valid high; total beats still 3.
- Snapshot and ignored start: change `flat_i` to all-ones and pulse `start_i` during SEND → streamed data unchanged; only one `done_o` pulse.
- Mid-frame reset: assert `rst_n`=0 during beat 1 → `m_valid_o`=0 immediately, `frame_cnt_o`=0; a fresh frame after release completes normally.
- Counter wrap and parity (with `NUMBERS_FLAT_PARITY_EN`):
  - Run 256 frames → `frame_cnt_o` wraps to 0.
  - Parity per beat: 32'h01234567 → 0, 32'h89ABCDEF → 0, 32'hF00D0000 → 1.
